// File: rtl/subleq_sequencer.sv
// subleq_sequencer: instruction FSM for the SUBLEQ machine.
// Sequences fetch/load/execute/writeback with a variable-latency memory
// handshake (timeout -> FAULT), halt detection, single-step mode, separate
// taken/not-taken PC strobes and a saturating retired-instruction counter.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   start              begin execution (sampled only in IDLE)
//   step_mode          return to IDLE after each instruction
//   clear              synchronous abort, highest priority after reset
//   mem_valid          memory read data valid for the current fetch
//   zero, negative     ALU flags, valid in WRITEBACK
//   c_addr, pc         branch target C and current PC
//   state              current state encoding
//   abc_ld .. pc_inc   datapath strobes
//   busy/halted/fault  status
//   instr_count        retired instructions, saturating
module subleq_sequencer #(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          CNT_W     = 16,
  parameter logic [ADDR_W-1:0]    HALT_ADDR = ADDR_W'(8'hFF),
  parameter int unsigned          TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              clear,
  input  logic              mem_valid,
  input  logic              zero,
  input  logic              negative,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic [3:0]        state,
  output logic              abc_ld,
  output logic              mem_ab_ld,
  output logic              result_ld,
  output logic              read_en_abc,
  output logic              read_en_ab,
  output logic              write_en_b,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_FETCH_ABC    = 4'd1,
    S_LOAD_ABC     = 4'd2,
    S_FETCH_MEM_AB = 4'd3,
    S_LOAD_MEM_AB  = 4'd4,
    S_EXECUTE      = 4'd5,
    S_WRITEBACK    = 4'd6,
    S_HALT         = 4'd7,
    S_FAULT        = 4'd8
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                taken;

  assign taken = zero | negative;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;       // any non-waiting cycle re-arms the counter for the next fetch
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:         if (start) state_d = S_FETCH_ABC;
      S_FETCH_ABC: begin
        // mem_valid on the TIMEOUT-th wait is still accepted
        if (mem_valid)                      state_d = S_LOAD_ABC;
        else if (wait_q == WAIT_W'(TIMEOUT)) state_d = S_FAULT;
        else                                wait_d  = wait_q + 1'b1;
      end
      S_LOAD_ABC:     state_d = S_FETCH_MEM_AB;
      S_FETCH_MEM_AB: begin
        if (mem_valid)                      state_d = S_LOAD_MEM_AB;
        else if (wait_q == WAIT_W'(TIMEOUT)) state_d = S_FAULT;
        else                                wait_d  = wait_q + 1'b1;
      end
      S_LOAD_MEM_AB:  state_d = S_EXECUTE;
      S_EXECUTE:      state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // a taken branch onto itself can never make progress, so treat it as halt
        if (taken && ((c_addr == HALT_ADDR) || (c_addr == pc))) state_d = S_HALT;
        else if (step_mode)                                     state_d = S_IDLE;
        else                                                    state_d = S_FETCH_ABC;
      end
      S_HALT:         state_d = S_HALT;
      S_FAULT:        state_d = S_FAULT;
      default:        state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      wait_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the registered state; only the writeback side effects
  // depend on live inputs so that clear can suppress them in the same cycle.
  assign state       = state_q;
  assign read_en_abc = (state_q == S_FETCH_ABC);
  assign abc_ld      = (state_q == S_LOAD_ABC);
  assign read_en_ab  = (state_q == S_FETCH_MEM_AB);
  assign mem_ab_ld   = (state_q == S_LOAD_MEM_AB);
  assign result_ld   = (state_q == S_EXECUTE);
  assign write_en_b  = (state_q == S_WRITEBACK) & ~clear;
  assign pc_ld       = (state_q == S_WRITEBACK) & ~clear & taken;
  assign pc_inc      = (state_q == S_WRITEBACK) & ~clear & ~taken;
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
module tb_subleq_sequencer;

  localparam logic [3:0] S_IDLE = 4'd0, S_FA = 4'd1, S_LA = 4'd2, S_FM = 4'd3,
                         S_LM = 4'd4, S_EX = 4'd5, S_WB = 4'd6, S_HALT = 4'd7,
                         S_FAULT = 4'd8;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, step_mode = 1'b0, clear = 1'b0, mem_valid = 1'b0;
  logic zero = 1'b0, negative = 1'b0;
  logic [7:0] c_addr = '0, pc = '0;

  logic [3:0]  state, state2;
  logic        abc_ld, mem_ab_ld, result_ld, read_en_abc, read_en_ab, write_en_b;
  logic        pc_ld, pc_inc, busy, halted, fault;
  logic        abc_ld2, mem_ab_ld2, result_ld2, read_en_abc2, read_en_ab2, write_en_b2;
  logic        pc_ld2, pc_inc2, busy2, halted2, fault2;
  logic [15:0] instr_count;
  logic [1:0]  instr_count2;

  subleq_sequencer #(.ADDR_W(8), .CNT_W(16), .HALT_ADDR(8'hFF), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .clear(clear),
    .mem_valid(mem_valid), .zero(zero), .negative(negative), .c_addr(c_addr), .pc(pc),
    .state(state), .abc_ld(abc_ld), .mem_ab_ld(mem_ab_ld), .result_ld(result_ld),
    .read_en_abc(read_en_abc), .read_en_ab(read_en_ab), .write_en_b(write_en_b),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .busy(busy), .halted(halted), .fault(fault),
    .instr_count(instr_count));

  subleq_sequencer #(.ADDR_W(8), .CNT_W(2), .HALT_ADDR(8'hFF), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .clear(clear),
    .mem_valid(mem_valid), .zero(zero), .negative(negative), .c_addr(c_addr), .pc(pc),
    .state(state2), .abc_ld(abc_ld2), .mem_ab_ld(mem_ab_ld2), .result_ld(result_ld2),
    .read_en_abc(read_en_abc2), .read_en_ab(read_en_ab2), .write_en_b(write_en_b2),
    .pc_ld(pc_ld2), .pc_inc(pc_inc2), .busy(busy2), .halted(halted2), .fault(fault2),
    .instr_count(instr_count2));

  always #5 clk = ~clk;

  // {abc_ld, mem_ab_ld, result_ld, read_en_abc, read_en_ab, write_en_b, pc_ld, pc_inc, busy, halted, fault}
  logic [10:0] act1, act2;
  assign act1 = {abc_ld, mem_ab_ld, result_ld, read_en_abc, read_en_ab, write_en_b,
                 pc_ld, pc_inc, busy, halted, fault};
  assign act2 = {abc_ld2, mem_ab_ld2, result_ld2, read_en_abc2, read_en_ab2, write_en_b2,
                 pc_ld2, pc_inc2, busy2, halted2, fault2};

  typedef struct {
    logic [3:0]  st;
    logic [10:0] outs;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_cnt2 = '0;

  // Expected strobe pattern for a state, given the inputs currently driven.
  function automatic logic [10:0] expect_outs(input logic [3:0] s);
    logic a, m, r, rabc, rab, w, pl, pi, b, h, f;
    {a, m, r, rabc, rab, w, pl, pi, b, h, f} = '0;
    case (s)
      S_FA:    begin rabc = 1'b1; b = 1'b1; end
      S_LA:    begin a = 1'b1;    b = 1'b1; end
      S_FM:    begin rab = 1'b1;  b = 1'b1; end
      S_LM:    begin m = 1'b1;    b = 1'b1; end
      S_EX:    begin r = 1'b1;    b = 1'b1; end
      S_WB: begin
        b  = 1'b1;
        w  = !clear;
        pl = (zero | negative) & !clear;
        pi = !(zero | negative) & !clear;
      end
      S_HALT:  h = 1'b1;
      S_FAULT: f = 1'b1;
      default: ;
    endcase
    return {a, m, r, rabc, rab, w, pl, pi, b, h, f};
  endfunction

  task automatic push_exp(input logic [3:0] s, input string nm);
    exp_t e;
    e.st = s; e.outs = expect_outs(s); e.cnt = exp_cnt; e.cnt2 = exp_cnt2; e.name = nm;
    sb.push_back(e);
  endtask

  // One cycle in which the DUT should be in state s.
  task automatic tick(input logic [3:0] s, input string nm);
    push_exp(s, nm);
    @(posedge clk); #1;
    if (clear) begin
      exp_cnt = '0; exp_cnt2 = '0;
    end else if (s == S_WB) begin
      if (exp_cnt != '1) exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 2'd1;
    end
  endtask

  // One instruction from its first FETCH_ABC cycle through WRITEBACK.
  task automatic run_instr(input int wa, input int wb, input logic abort, input string nm);
    mem_valid = 1'b0;
    repeat (wa) tick(S_FA, {nm, "_wait_abc"});
    mem_valid = 1'b1;
    tick(S_FA, {nm, "_fetch_abc"});
    tick(S_LA, {nm, "_load_abc"});
    mem_valid = 1'b0;
    repeat (wb) tick(S_FM, {nm, "_wait_ab"});
    mem_valid = 1'b1;
    tick(S_FM, {nm, "_fetch_ab"});
    tick(S_LM, {nm, "_load_ab"});
    tick(S_EX, {nm, "_execute"});
    clear = abort;
    tick(S_WB, {nm, "_writeback"});
    clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (state !== mon_e.st) begin
        errors++;
        $display("FAIL %s state actual=%0d required=%0d", mon_e.name, state, mon_e.st);
      end
      checks++;
      if (act1 !== mon_e.outs) begin
        errors++;
        $display("FAIL %s strobes actual=%b required=%b", mon_e.name, act1, mon_e.outs);
      end
      checks++;
      if (instr_count !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s instr_count actual=%0d required=%0d", mon_e.name, instr_count, mon_e.cnt);
      end
      checks++;
      if ({state2, act2} !== {mon_e.st, mon_e.outs}) begin
        errors++;
        $display("FAIL %s cnt2_inst state/strobes actual=%h/%b required=%h/%b",
                 mon_e.name, state2, act2, mon_e.st, mon_e.outs);
      end
      checks++;
      if (instr_count2 !== mon_e.cnt2) begin
        errors++;
        $display("FAIL %s instr_count_sat actual=%0d required=%0d", mon_e.name, instr_count2, mon_e.cnt2);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    tick(S_IDLE, "reset");
    rst = 1'b1;
    tick(S_IDLE, "idle_hold");

    // zero-wait, not taken
    c_addr = 8'h10; pc = 8'h00; zero = 1'b0; negative = 1'b0; mem_valid = 1'b1;
    start = 1'b1; tick(S_IDLE, "t1_start"); start = 1'b0;
    run_instr(0, 0, 1'b0, "t1");

    // taken, ordinary target, continues straight into the next fetch
    negative = 1'b1; c_addr = 8'h20; pc = 8'h03;
    run_instr(0, 0, 1'b0, "t2");

    // taken to HALT_ADDR
    c_addr = 8'hFF; pc = 8'h20;
    run_instr(0, 0, 1'b0, "t3");
    start = 1'b1; mem_valid = 1'b1;
    repeat (10) tick(S_HALT, "halt_hold");
    start = 1'b0; clear = 1'b1;
    tick(S_HALT, "halt_clear");
    clear = 1'b0;
    tick(S_IDLE, "after_halt_clear");

    // memory waits and timeout
    negative = 1'b0; zero = 1'b0;
    start = 1'b1; tick(S_IDLE, "t4_start"); start = 1'b0;
    run_instr(0, 3, 1'b0, "t4_ab3");
    run_instr(15, 0, 1'b0, "t4_abc16");
    mem_valid = 1'b0;
    repeat (16) tick(S_FA, "t4_timeout_wait");
    mem_valid = 1'b1;
    repeat (3) tick(S_FAULT, "t4_fault");
    clear = 1'b1; tick(S_FAULT, "fault_clear"); clear = 1'b0;
    tick(S_IDLE, "after_fault_clear");

    // single-step
    step_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; tick(S_IDLE, "step_start"); start = 1'b0;
      run_instr(0, 0, 1'b0, "step");
      tick(S_IDLE, "step_idle");
    end
    step_mode = 1'b0;
    start = 1'b1; tick(S_IDLE, "sat_start"); start = 1'b0;
    run_instr(0, 0, 1'b0, "sat");

    // asynchronous reset while in EXECUTE
    mem_valid = 1'b1;
    tick(S_FA, "rst_fa"); tick(S_LA, "rst_la"); tick(S_FM, "rst_fm"); tick(S_LM, "rst_lm");
    #2 rst = 1'b0;
    exp_cnt = '0; exp_cnt2 = '0;
    push_exp(S_IDLE, "async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    tick(S_IDLE, "post_reset");

    // abort during WRITEBACK
    start = 1'b1; tick(S_IDLE, "abort_start"); start = 1'b0;
    run_instr(0, 0, 1'b0, "pre_abort");
    run_instr(0, 0, 1'b1, "abort");
    tick(S_IDLE, "after_abort");

    // taken self-loop halts; start ignored outside IDLE; start+clear -> IDLE
    zero = 1'b1; c_addr = 8'h40; pc = 8'h40;
    start = 1'b1; tick(S_IDLE, "loop_start"); start = 1'b0;
    run_instr(0, 0, 1'b0, "selfloop");
    start = 1'b1; tick(S_HALT, "halt_start_ignored");
    clear = 1'b1; tick(S_HALT, "halt_start_clear");
    tick(S_IDLE, "idle_start_clear");
    start = 1'b0; clear = 1'b0;
    tick(S_IDLE, "final_idle");

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subleq_sequencer.md
# subleq_sequencer

Parametrised successor to the SUBLEQ control decoder. It owns the instruction FSM and generates the same per-state register-load and memory-enable strobes. It adds the following:
- a variable-latency memory handshake with timeout fault
- halt detection
- single-instruction step mode
- separate taken/not-taken PC strobes
- a retired-instruction counter

It sits between the memory subsystem and the datapath (ABC registers, mem_a/mem_b registers, ALU, PC).

## Interface
Parameters:
- ADDR_W, 8, width of c_addr and pc
- CNT_W, 16, width of instr_count
- HALT_ADDR, 8'hFF, taken-branch target that halts the machine (width ADDR_W)
- TIMEOUT, 15, maximum cycles a fetch state waits for mem_valid before FAULT (≥1)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin execution; sampled only in IDLE
- step_mode  in  1  when 1, return to IDLE after each instruction
- clear  in  1  synchronous abort/clear, highest priority after reset
- mem_valid  in  1  memory read data valid for the current fetch
- zero, negative  in  1 each  ALU flags, valid in WRITEBACK
- c_addr  in  ADDR_W  branch target C of current instruction
- pc  in  ADDR_W  current PC
- state  out  4  current state encoding
- abc_ld, mem_ab_ld, result_ld, read_en_abc, read_en_ab, write_en_b  out  1 each  datapath strobes
- pc_ld  out  1  load PC with c_addr (branch taken)
- pc_inc  out  1  PC += 3 (branch not taken)
- busy  out  1  state is neither IDLE, HALT nor FAULT
- halted, fault  out  1 each  state is HALT / FAULT
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- States and encoding: IDLE=0, FETCH_ABC=1, LOAD_ABC=2, FETCH_MEM_AB=3, LOAD_MEM_AB=4, EXECUTE=5, WRITEBACK=6, HALT=7, FAULT=8. Other codes go to IDLE.
- IDLE: all strobes are 0. start=1 goes to FETCH_ABC.
- FETCH_ABC: read_en_abc=1 every cycle in the state. On mem_valid=1, go to LOAD_ABC.
- LOAD_ABC: abc_ld=1, then go to FETCH_MEM_AB.
- FETCH_MEM_AB: read_en_ab=1 every cycle in the state. On mem_valid=1, go to LOAD_MEM_AB.
- LOAD_MEM_AB: mem_ab_ld=1, then go to EXECUTE.
- EXECUTE: result_ld=1, then go to WRITEBACK.
- WRITEBACK:
  - write_en_b=1.
  - taken = zero | negative. pc_ld=taken, pc_inc=~taken; never both.
  - instr_count increments, holding at all-ones.
  - Next state, in priority order:
    1. HALT if taken and (c_addr==HALT_ADDR or c_addr==pc). The self-loop counts as a halt.
    2. IDLE if step_mode=1.
    3. Otherwise FETCH_ABC.
- HALT / FAULT: no strobes; held until clear or reset.
- Wait counter:
  - Cleared on entry to each fetch state.
  - Increments each cycle in a fetch state with mem_valid=0.
  - If it reaches TIMEOUT with mem_valid still 0, go to FAULT.
  - mem_valid=1 in the same cycle as the counter reaches TIMEOUT is accepted, not a fault.
- clear=1, any state:
  - Next state is IDLE; instr_count clears to 0.
  - In that cycle, write_en_b, pc_ld and pc_inc are forced to 0, so an aborted WRITEBACK has no side effects.
  - Other strobes still follow the state.
- start while not in IDLE is ignored. start and clear together go to IDLE.
- mem_valid outside fetch states is ignored.

## Timing
- Reset (rst=0), asynchronous:
  - state=IDLE, instr_count=0, wait counter=0.
  - All strobes, busy, halted and fault are 0.
- Outputs are Moore-decoded from registered state; the clear gating and pc_ld/pc_inc are combinational.
- Zero-wait memory (mem_valid=1 on first fetch cycle): 6 cycles per instruction, start to first WRITEBACK is 6 edges.
- Each cycle without mem_valid adds one cycle to the corresponding fetch state.
- Back-to-back instructions: WRITEBACK is followed directly by FETCH_ABC, with no idle cycle.
- Deassertion of rst is assumed synchronised externally.

## Test plan
- Zero-wait, non-taken run: start pulse, mem_valid=1, zero=negative=0, c_addr=8'h10, pc=8'h00 → each state lasts one cycle; pc_inc=1 in WRITEBACK; instr_count=1 after 6 cycles; busy stays high.
- Taken branch: negative=1, c_addr=8'h20, pc=8'h03 → pc_ld=1, pc_inc=0 in WRITEBACK; next state FETCH_ABC. Then c_addr=8'hFF → HALT; halted=1; strobes stay 0 for 10 cycles.
- Wait and timeout:
  - mem_valid delayed 3 cycles in FETCH_MEM_AB → read_en_ab high for 4 cycles, then LOAD_MEM_AB.
  - mem_valid held 0 with TIMEOUT=15 → FAULT after 16 FETCH_ABC cycles.
  - mem_valid=1 on the 16th cycle → LOAD_ABC.
- Step mode: step_mode=1, three start pulses → three instructions, IDLE between each; instr_count=3.
- Abort: clear=1 during WRITEBACK → write_en_b=0, pc_ld=0, pc_inc=0 that cycle; next state IDLE; instr_count=0.
- Reset mid-instruction: rst=0 asynchronously in EXECUTE → all outputs 0 before the next clk edge; saturation check with CNT_W=2 gives instr_count holding at 3.
